// File: rtl/bank_wr_ctrl.sv
// bank_wr_ctrl: write controller for a four-slot register bank.
// Accepts bytes over a valid/ready handshake and places them in the bank.
// The slot is either the next sequential slot or an explicit address.
// The bank sees a registered strobe, a one-hot slot enable and the data one
// cycle after the byte is accepted. A clear writes zero to all four slots.
module bank_wr_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_addr,
    input  logic         addr_mode,
    input  logic         clear,
    output logic         wr,
    output logic [3:0]   en,
    output logic [W-1:0] d,
    output logic [3:0]   valid_mask,
    output logic         full,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Converts a 2-bit slot index into the bank's one-hot enable.
    function automatic logic [3:0] slot_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t       state_q, state_d;
    logic [1:0]   wptr_q, wptr_d;
    logic [3:0]   mask_q, mask_d;
    logic         wr_q, wr_d;
    logic [3:0]   en_q, en_d;
    logic [W-1:0] data_q, data_d;

    logic         full_s;
    logic         accept_s;
    logic [1:0]   slot_s;
    logic [3:0]   slot_oh_s;
    logic [3:0]   mask_upd_s;

    // Handshake: clear wins over data. While FULL, only addressed writes
    // may go through; sequential bytes stay pending upstream.
    always_comb begin
        full_s     = (mask_q == 4'b1111);
        in_ready   = ~clear & (state_q != ST_CLEAR) & (addr_mode | ~full_s);
        accept_s   = in_valid & in_ready;
        slot_s     = addr_mode ? in_addr : wptr_q;
        slot_oh_s  = slot_onehot(slot_s);
        mask_upd_s = mask_q | slot_oh_s;
    end

    // Next-state and next-output logic. The FSM transition is chosen
    // first, then a clear overrides everything.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        mask_d  = mask_q;
        wr_d    = 1'b0;
        en_d    = 4'b0000;
        data_d  = data_q;

        if (accept_s) begin
            wr_d   = 1'b1;
            en_d   = slot_oh_s;
            data_d = in_data;
            mask_d = mask_upd_s;
            if (!addr_mode) begin
                wptr_d = wptr_q + 2'd1;
            end else begin
                wptr_d = wptr_q;
            end
        end else begin
            wr_d = 1'b0;
        end

        case (state_q)
            ST_EMPTY, ST_FILL: begin
                if (accept_s) begin
                    state_d = (mask_upd_s == 4'b1111) ? ST_FULL : ST_FILL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FULL:  state_d = ST_FULL;
            ST_CLEAR: state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (clear) begin
            state_d = ST_CLEAR;
            wptr_d  = 2'd0;
            mask_d  = 4'b0000;
            wr_d    = 1'b1;
            en_d    = 4'b1111;
            data_d  = {W{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // State and registered bank-side outputs; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            wptr_q  <= 2'd0;
            mask_q  <= 4'b0000;
            wr_q    <= 1'b0;
            en_q    <= 4'b0000;
            data_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    // Output port mapping.
    always_comb begin
        wr         = wr_q;
        en         = en_q;
        d          = data_q;
        valid_mask = mask_q;
        full       = full_s;
        state      = state_q;
    end

endmodule

// File: tb/tb_bank_wr_ctrl.sv
// Testbench for bank_wr_ctrl: directed scenarios plus a randomized run
// checked against a slot-level behavioural model.
module tb_bank_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_addr;
    logic       addr_mode;
    logic       clear;
    logic       wr;
    logic [3:0] en;
    logic [7:0] d;
    logic [3:0] valid_mask;
    logic       full;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    bank_wr_ctrl #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .addr_mode(addr_mode),
        .clear(clear), .wr(wr), .en(en), .d(d), .valid_mask(valid_mask),
        .full(full), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: which slots hold data, next sequential slot, phase.
    bit       m_slot_valid [4];
    int       m_wptr;
    int       m_phase;      // 0 empty, 1 filling, 2 full, 3 clearing
    bit       m_wr;
    int       m_en;
    int       m_d;
    bit       exp_ready;
    logic     obs_ready;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += m_slot_valid[i];
        return c;
    endfunction

    function automatic int m_mask();
        int mk = 0;
        for (int i = 0; i < 4; i++) if (m_slot_valid[i]) mk += (1 << i);
        return mk;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot_valid[i] = 1'b0;
        m_wptr = 0; m_phase = 0; m_wr = 1'b0; m_en = 0; m_d = 0;
    endtask

    task automatic model_step(input bit v, input int data, input int addr,
                              input bit mode, input bit clr);
        int slot;
        exp_ready = !clr && (m_phase != 3) && (mode || m_count() != 4);
        m_wr = 1'b0;
        m_en = 0;
        if (clr) begin
            for (int i = 0; i < 4; i++) m_slot_valid[i] = 1'b0;
            m_wptr = 0; m_phase = 3; m_wr = 1'b1; m_en = 15; m_d = 0;
        end else if (m_phase == 3) begin
            m_phase = 0;
        end else if (v && exp_ready) begin
            slot = mode ? addr : m_wptr;
            if (!mode) m_wptr = (m_wptr + 1) % 4;
            m_slot_valid[slot] = 1'b1;
            m_wr = 1'b1; m_en = 1 << slot; m_d = data;
            m_phase = (m_count() == 4) ? 2 : 1;
        end
    endtask

    // One clock: drive inputs, capture in_ready mid-cycle, step the model.
    task automatic cycle(input bit v, input int data, input int addr,
                         input bit mode, input bit clr);
        in_valid = v; in_data = data[7:0]; in_addr = addr[1:0];
        addr_mode = mode; clear = clr;
        @(negedge clk);
        obs_ready = in_ready;
        @(posedge clk);
        #1;
        model_step(v, data, addr, mode, clr);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_addr = 2'd0;
        addr_mode = 1'b0; clear = 1'b0;
        model_reset();
        #3;
        total++;
        if ({wr, en, d, valid_mask, full, state} !== 20'h0) begin
            bad++;
            $display("FAIL reset_vals got=%0h exp=0", {wr, en, d, valid_mask, full, state});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq_fill();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 17 * (i + 1), 0, 1'b0, 1'b0);
            total++;
            if (obs_ready !== 1'b1 || wr !== 1'b1 || en !== 4'(1 << i) || d !== 8'(17 * (i + 1))) begin
                bad++;
                $display("FAIL seq_fill i=%0d rdy=%0b wr=%0b en=%0b d=%0h exp en=%0b d=%0h",
                         i, obs_ready, wr, en, d, 4'(1 << i), 8'(17 * (i + 1)));
            end
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (valid_mask !== 4'hF || full !== 1'b1 || state !== 2'd2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL seq_full mask=%0b full=%0b st=%0d rdy=%0b exp 1111/1/2/0",
                     valid_mask, full, state, in_ready);
        end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h55, 0, 1'b0, 1'b0);
            total++;
            if (obs_ready !== 1'b0 || wr !== 1'b0 || state !== 2'd2) begin
                bad++;
                $display("FAIL stall i=%0d rdy=%0b wr=%0b st=%0d exp 0/0/2", i, obs_ready, wr, state);
            end
        end
        cycle(1'b1, 8'h55, 0, 1'b0, 1'b1);
        total++;
        if (wr !== 1'b1 || en !== 4'hF || d !== 8'h00 || state !== 2'd3 || valid_mask !== 4'h0) begin
            bad++;
            $display("FAIL stall_clear wr=%0b en=%0b d=%0h st=%0d mask=%0b", wr, en, d, state, valid_mask);
        end
        cycle(1'b1, 8'h55, 0, 1'b0, 1'b0);
        total++;
        if (obs_ready !== 1'b0 || wr !== 1'b0 || state !== 2'd0) begin
            bad++;
            $display("FAIL clear_exit rdy=%0b wr=%0b st=%0d exp 0/0/0", obs_ready, wr, state);
        end
        cycle(1'b1, 8'h55, 0, 1'b0, 1'b0);
        total++;
        if (wr !== 1'b1 || en !== 4'b0001 || d !== 8'h55 || state !== 2'd1) begin
            bad++;
            $display("FAIL pending_byte wr=%0b en=%0b d=%0h st=%0d exp 1/0001/55/1", wr, en, d, state);
        end
    endtask

    task automatic test_addressed();
        for (int i = 1; i < 4; i++) cycle(1'b1, i, 0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 2, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 1'b1 || en !== 4'b0100 || d !== 8'hA5 || valid_mask !== 4'hF || state !== 2'd2) begin
            bad++;
            $display("FAIL addr_ovw rdy=%0b en=%0b d=%0h mask=%0b st=%0d", obs_ready, en, d, valid_mask, state);
        end
    endtask

    task automatic test_clear_collision();
        cycle(1'b1, 8'h77, 0, 1'b1, 1'b1);
        total++;
        if (obs_ready !== 1'b0 || wr !== 1'b1 || en !== 4'hF || d !== 8'h00 || state !== 2'd3) begin
            bad++;
            $display("FAIL collide rdy=%0b wr=%0b en=%0b d=%0h st=%0d", obs_ready, wr, en, d, state);
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        total++;
        if (wr !== 1'b1 || en !== 4'hF || state !== 2'd3) begin
            bad++;
            $display("FAIL clear_hold wr=%0b en=%0b st=%0d exp 1/1111/3", wr, en, state);
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        total++;
        if (wr !== 1'b0 || en !== 4'h0 || d !== 8'h00 || state !== 2'd0) begin
            bad++;
            $display("FAIL collide_exit wr=%0b en=%0b d=%0h st=%0d", wr, en, d, state);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'h31, 0, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({wr, en, d, valid_mask, full, state} !== 20'h0) begin
            bad++;
            $display("FAIL async_rst got=%0h exp=0", {wr, en, d, valid_mask, full, state});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h9C, 0, 1'b0, 1'b0);
        total++;
        if (wr !== 1'b1 || en !== 4'b0001 || d !== 8'h9C) begin
            bad++;
            $display("FAIL post_rst wr=%0b en=%0b d=%0h exp 1/0001/9c", wr, en, d);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA0, 0, 1'b1, 1'b0);
        cycle(1'b1, 8'hA1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hB0 + i, 3, 1'b0, 1'b0);
            total++;
            if (wr !== 1'b1 || en !== 4'(1 << i)) begin
                bad++;
                $display("FAIL wrap_seq i=%0d wr=%0b en=%0b exp 1/%0b", i, wr, en, 4'(1 << i));
            end
        end
        total++;
        if (valid_mask !== 4'b0111 || state !== 2'd1 || full !== 1'b0) begin
            bad++;
            $display("FAIL wrap_state mask=%0b st=%0d full=%0b exp 0111/1/0", valid_mask, state, full);
        end
        cycle(1'b1, 8'hB3, 0, 1'b0, 1'b0);
        total++;
        if (en !== 4'b1000 || state !== 2'd2) begin
            bad++;
            $display("FAIL wrap_wptr en=%0b st=%0d exp 1000/2", en, state);
        end
    endtask

    task automatic test_random();
        bit v, mode, clr;
        int data, addr;
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 1);
            clr  = ($urandom_range(0, 15) == 0);
            data = $urandom_range(0, 255);
            addr = $urandom_range(0, 3);
            cycle(v, data, addr, mode, clr);
            total++;
            if (obs_ready !== exp_ready || wr !== m_wr || en !== 4'(m_en) || d !== 8'(m_d) ||
                valid_mask !== 4'(m_mask()) || full !== (m_count() == 4) || state !== 2'(m_phase)) begin
                bad++;
                $display("FAIL random n=%0d got rdy=%0b wr=%0b en=%0b d=%0h mask=%0b full=%0b st=%0d exp rdy=%0b wr=%0b en=%0b d=%0h mask=%0b full=%0b st=%0d",
                         n, obs_ready, wr, en, d, valid_mask, full, state,
                         exp_ready, m_wr, 4'(m_en), 8'(m_d), 4'(m_mask()), (m_count() == 4), 2'(m_phase));
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq_fill();
        test_full_stall();
        test_addressed();
        test_clear_collision();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
